// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the dual-requester AES controller: FSM states,
// op codes, block width and the GF(2^8) / key-schedule helpers used by
// both AES cores.
package aes_ctrl_pkg;

    localparam int BLK_W = 128;

    localparam logic OP_ENC = 1'b0;
    localparam logic OP_DEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        OUT  = 2'd2
    } state_t;

    // AES byte 0 lives in the most significant byte, so byte k is element 15-k
    typedef logic [15:0][7:0] blk_bytes_t;

    // Multiply by x in GF(2^8) with the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply, shift-and-add
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        logic [7:0] bb;
        acc = 8'h00;
        aa  = a;
        bb  = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) begin
                acc = acc ^ aa;
            end
            aa = xtime(aa);
            bb = {1'b0, bb[7:1]};
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as AES requires)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) begin
                r = gmul(r, p);
            end
            p = gmul(p, p);
        end
        return r;
    endfunction

    // Forward S-box: inverse followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine transform followed by the field inverse
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] x;
        x = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(x);
    endfunction

    // One step of the AES-128 key schedule, producing the next round key
    function automatic logic [127:0] next_round_key(input logic [127:0] rk,
                                                    input logic [7:0]   rcon);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = rk[127:96];
        w1 = rk[95:64];
        w2 = rk[63:32];
        w3 = rk[31:0];
        t  = {w3[23:0], w3[31:24]};
        t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        t  = t ^ {rcon, 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_decrypt.sv
// AES-128 decryption core (straight inverse cipher): the full key schedule
// is expanded, then applied in reverse, and the plaintext is registered.
module aes_decrypt
    import aes_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic [127:0] mKey,
    input  logic [127:0] data_in,
    output logic [127:0] decryptedData
);

    function automatic blk_bytes_t inv_sub_bytes(input blk_bytes_t b);
        blk_bytes_t o;
        for (int k = 0; k < 16; k++) begin
            o[k] = inv_sbox(b[k]);
        end
        return o;
    endfunction

    // Row r rotates right by r columns
    function automatic blk_bytes_t inv_shift_rows(input blk_bytes_t b);
        blk_bytes_t o;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[15 - (r + 4 * c)] = b[15 - (r + 4 * ((c - r + 4) % 4))];
            end
        end
        return o;
    endfunction

    function automatic blk_bytes_t inv_mix_columns(input blk_bytes_t b);
        blk_bytes_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = b[15 - 4 * c];
            a1 = b[14 - 4 * c];
            a2 = b[13 - 4 * c];
            a3 = b[12 - 4 * c];
            o[15 - 4 * c] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[14 - 4 * c] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[13 - 4 * c] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[12 - 4 * c] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] key,
                                             input logic [127:0] ct);
        logic [127:0] rks [11];
        logic [7:0]   rcon;
        blk_bytes_t   s;
        rks[0] = key;
        rcon   = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            rks[r] = next_round_key(rks[r - 1], rcon);
            rcon   = xtime(rcon);
        end
        s = ct ^ rks[10];
        for (int r = 9; r >= 0; r--) begin
            s = inv_shift_rows(s);
            s = inv_sub_bytes(s);
            s = s ^ rks[r];
            if (r != 0) begin
                s = inv_mix_columns(s);
            end
        end
        return s;
    endfunction

    // Capture the plaintext every cycle; the controller picks when to use it
    always_ff @(posedge clk) begin
        decryptedData <= aes_dec(mKey, data_in);
    end

endmodule

// File: rtl/aes_encrypt.sv
// AES-128 encryption core: the full cipher is evaluated from the key and
// block presented this cycle and captured in the output register.
module aes_encrypt
    import aes_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic [127:0] mKey,
    input  logic [127:0] data_in,
    output logic [127:0] encryptedData
);

    function automatic blk_bytes_t sub_bytes(input blk_bytes_t b);
        blk_bytes_t o;
        for (int k = 0; k < 16; k++) begin
            o[k] = sbox(b[k]);
        end
        return o;
    endfunction

    // Row r rotates left by r columns
    function automatic blk_bytes_t shift_rows(input blk_bytes_t b);
        blk_bytes_t o;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[15 - (r + 4 * c)] = b[15 - (r + 4 * ((c + r) % 4))];
            end
        end
        return o;
    endfunction

    function automatic blk_bytes_t mix_columns(input blk_bytes_t b);
        blk_bytes_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = b[15 - 4 * c];
            a1 = b[14 - 4 * c];
            a2 = b[13 - 4 * c];
            a3 = b[12 - 4 * c];
            o[15 - 4 * c] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[14 - 4 * c] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[13 - 4 * c] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[12 - 4 * c] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] key,
                                             input logic [127:0] pt);
        blk_bytes_t   s;
        logic [127:0] rk;
        logic [7:0]   rcon;
        rk   = key;
        s    = pt ^ rk;
        rcon = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            rk   = next_round_key(rk, rcon);
            rcon = xtime(rcon);
            s    = sub_bytes(s);
            s    = shift_rows(s);
            if (r != 10) begin
                s = mix_columns(s);
            end
            s = s ^ rk;
        end
        return s;
    endfunction

    // Capture the ciphertext every cycle; the controller picks when to use it
    always_ff @(posedge clk) begin
        encryptedData <= aes_enc(mKey, data_in);
    end

endmodule

// File: rtl/aes_rr_arb2.sv
// Two-input round-robin arbiter. When both requesters are active the one
// that did not win last time gets the grant; the memory of the last winner
// only moves when the grant is actually taken.
module aes_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       grant_idx
);

    logic last_grant;

    // Pick the winner from the live requests and the previous winner
    always_comb begin
        grant_idx = 1'b0;
        grant     = 2'b00;
        case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'b0;
        endcase
        if (req != 2'b00) begin
            grant = grant_idx ? 2'b10 : 2'b01;
        end
    end

    // Remember the winner; starting at 1 makes requester 0 win the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (advance) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/aes_dual_req_ctrl.sv
// Shares one AES encrypt core and one decrypt core between the TX (req0) and
// RX (req1) paths. Owns the master key, arbitrates blocks round-robin and
// returns each result tagged with requester id and op over a valid/ready port.
module aes_dual_req_ctrl #(
    parameter int KEY_W = 128,
    parameter int BLK_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key_in,
    output logic             key_ready,
    input  logic [1:0]       req_valid,
    input  logic [1:0]       req_op,
    input  logic [BLK_W-1:0] req_data0,
    input  logic [BLK_W-1:0] req_data1,
    output logic [1:0]       req_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             out_id,
    output logic             out_op,
    output logic             key_loaded
);

    import aes_ctrl_pkg::*;

    state_t           state;
    logic [KEY_W-1:0] key_reg;
    logic [BLK_W-1:0] op_data;
    logic             op_reg;
    logic             id_reg;

    logic             in_idle;
    logic             in_out;
    logic             accept;
    logic [1:0]       grant;
    logic             grant_idx;
    logic [BLK_W-1:0] enc_result;
    logic [BLK_W-1:0] dec_result;

    aes_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    aes_encrypt u_enc (
        .clk           (clk),
        .mKey          (key_reg),
        .data_in       (op_data),
        .encryptedData (enc_result)
    );

    aes_decrypt u_dec (
        .clk           (clk),
        .mKey          (key_reg),
        .data_in       (op_data),
        .decryptedData (dec_result)
    );

    // Handshake qualifiers; a pending key load always beats a block request
    always_comb begin
        in_idle = (state == IDLE) && !rst;
        in_out  = (state == OUT) && !rst;
        accept  = in_idle && !key_valid && key_loaded && (req_valid != 2'b00);
    end

    assign key_ready = in_idle;
    assign req_ready = accept ? grant : 2'b00;
    assign out_valid = in_out;
    assign out_data  = in_out ? ((op_reg == OP_DEC) ? dec_result : enc_result) : '0;
    assign out_id    = in_out & id_reg;
    assign out_op    = in_out & op_reg;

    // Controller FSM: key loads and block grants in IDLE, one cycle for the
    // cores to capture, then hold the result until downstream takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            key_reg    <= '0;
            key_loaded <= 1'b0;
            op_data    <= '0;
            op_reg     <= 1'b0;
            id_reg     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        key_reg    <= key_in;
                        key_loaded <= 1'b1;
                    end else if (accept) begin
                        op_data <= grant_idx ? req_data1 : req_data0;
                        op_reg  <= req_op[grant_idx];
                        id_reg  <= grant_idx;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    state <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/aes_dual_req_ctrl.md
Name: aes_dual_req_ctrl

Overview:
Controller sharing one aes_encrypt and one aes_decrypt core between two requesters (req0 = TX path, req1 = RX path). It owns the master-key register, round-robin arbitrates block requests and sequences the cores. Results return with requester id and op through a valid/ready output port. Sits between the UART framing logic and the AES cores.

Parameters:
- KEY_W, 128, master key width (fixed to 128; only value supported)
- BLK_W, 128, block width (fixed to 128)

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous active-high reset
- key_valid  in  1  master-key load request
- key_in  in  128  master key
- key_ready  out  1  key accepted when key_valid & key_ready
- req_valid  in  2  per-requester block valid (bit i = requester i)
- req_op  in  2  per-requester op, 0 = encrypt, 1 = decrypt
- req_data0  in  128  requester 0 block
- req_data1  in  128  requester 1 block
- req_ready  out  2  per-requester accept strobe (one-hot or zero)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  128  result block; 0 when out_valid = 0
- out_id  out  1  requester the result belongs to
- out_op  out  1  op performed
- key_loaded  out  1  a key has been loaded since reset

Behaviour:
- Reset (rst high at posedge): state = IDLE, key_reg = 0, key_loaded = 0, last_grant = 1, op_data = 0. While rst is high: key_ready = 0, req_ready = 0, out_valid = 0, out_data = 0, out_id = 0, out_op = 0. Reset mid-operation drops the in-flight block with no output.
- FSM states: IDLE, LOAD, OUT.
- IDLE:
  - key_ready = 1.
  - If key_valid: key_reg <= key_in and key_loaded <= 1. No block is accepted that cycle (key has priority). Stay in IDLE.
  - Else if key_loaded and any req_valid: arbiter grants; req_ready[g] = 1 for exactly this cycle. Latch op_data, op_reg, id_reg <= g. last_grant <= g. Go to LOAD.
  - Requests are ignored while key_loaded = 0.
- LOAD: op_data drives both cores; the cores' output registers capture at the end of this cycle. Go to OUT unconditionally.
- OUT:
  - out_valid = 1.
  - out_data = op_reg ? decryptedData : encryptedData.
  - out_id = id_reg, out_op = op_reg.
  - Outputs stay stable while out_ready = 0; op_data and key_reg are frozen, so the core outputs are stable.
  - out_ready = 1: go to IDLE.
- key_ready = 0 and req_ready = 0 in LOAD and OUT. A key change therefore never corrupts an in-flight block.
- Latency: req_ready cycle T, out_valid first high in T+2. Peak throughput is 1 block per 3 cycles.
- Round-robin: one requester valid gets the grant. Both valid: grant = ~last_grant. So after reset, requester 0 wins the first contention.
- Both cores receive key_reg as mKey. Both cores clock every cycle; only the selected result is used.
- req_op of the non-granted requester is don't-care.

Decomposition:
- Shared package aes_ctrl_pkg: state encoding (IDLE = 2'd0, LOAD = 2'd1, OUT = 2'd2), OP_ENC = 1'b0, OP_DEC = 1'b1, BLK_W = 128.
- Sub-module aes_rr_arb2: 2-input round-robin arbiter.
  - Inputs: clk, rst, req[1:0], advance.
  - Outputs: grant[1:0] one-hot, grant_idx.
  - Holds last_grant, updated when advance is high.
- aes_encrypt and aes_decrypt are instantiated inside this controller.

Test Plan:
- Reset, then req_valid = 2'b01 with no key loaded → req_ready stays 0 for 10 cycles, out_valid = 0, key_loaded = 0.
- Load key 000102030405060708090a0b0c0d0e0f. Then req0 encrypt 00112233445566778899aabbccddeeff → req_ready = 2'b01 at T. At T+2: out_valid = 1, out_data = 69c4e0d86a7b0430d8cdb78070b4c55a, out_id = 0, out_op = 0.
- Same key, req1 decrypt 69c4e0d86a7b0430d8cdb78070b4c55a → out_data = 00112233445566778899aabbccddeeff, out_id = 1, out_op = 1.
- Both requesters valid continuously after reset → grants alternate 0, 1, 0, 1. A new grant occurs every 3 cycles with out_ready tied high.
- Hold out_ready = 0 for 5 cycles in OUT while pulsing key_valid with a new key:
  - out_data stays stable; key_ready = 0; key_reg is unchanged.
  - After out_ready rises, the key is accepted in the following IDLE cycle and the next block uses it.
- Assert rst during LOAD → next cycle out_valid = 0 and key_loaded = 0. No stale output appears after reset deasserts.
